// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM encoding and AXI response/protection codes.
`default_nettype none

package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } axil_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready command port into one AXI
// read or write transaction and returns the result on a valid/ready response port.
`default_nettype none

module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  a_clk,
  input  logic                  a_rst,

  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  input  logic                  cmd_write,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,

  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  axil_state_e state_q, state_d;

  logic cmd_ready_q, cmd_ready_d;
  logic awvalid_q,   awvalid_d;
  logic wvalid_q,    wvalid_d;
  logic bready_q,    bready_d;
  logic arvalid_q,   arvalid_d;
  logic rready_q,    rready_d;
  logic rsp_valid_q, rsp_valid_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q,  resp_d;
  logic                  accept;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Datapath holding registers carry no reset; their contents only matter once a command is accepted.
  always_ff @(posedge a_clk) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
      write_q <= cmd_write;
    end
    rdata_q <= rdata_d;
    resp_q  <= resp_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          accept      = 1'b1;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W complete independently; move on only when neither is still pending.
      ST_WR_AW_W: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end

      ST_WR_B: begin
        if (m_axil_bvalid) begin
          resp_d      = m_axil_bresp;
          rdata_d     = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RD_AR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end

      ST_RD_R: begin
        if (m_axil_rvalid) begin
          rdata_d     = m_axil_rdata;
          resp_d      = m_axil_rresp;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;

  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_write = write_q;
  assign rsp_valid = rsp_valid_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = AXI_PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = AXI_PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a behavioural AXI4-Lite memory slave and a response scoreboard.
`default_nettype none

module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        a_clk = 1'b0;
  logic        a_rst;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_write, cmd_valid, cmd_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write, rsp_valid, rsp_ready;
  logic [15:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  always #5 a_clk = ~a_clk;

  axil_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .cmd_write(cmd_write), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        write;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int exp_rsp = 0;
  int rsp_cnt = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = AXI_RESP_OKAY;
  logic [1:0] r_resp_cfg = AXI_RESP_OKAY;
  logic b_hold = 1'b0;
  logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [15:0] aw_addr_l, ar_addr_l;
  logic [31:0] w_data_l;
  logic [3:0]  w_strb_l;
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Slave: ready/valid driven just after the rising edge, handshakes observed on the falling edge.
  initial begin
    m_axil_awready = 1'b0;
    forever begin
      @(posedge a_clk); #1;
      if (m_axil_awvalid === 1'b1 && !a_rst) begin
        repeat (aw_dly) begin @(posedge a_clk); #1; end
        m_axil_awready = 1'b1;
        @(posedge a_clk); #1;
        m_axil_awready = 1'b0;
      end
    end
  end

  initial begin
    m_axil_wready = 1'b0;
    forever begin
      @(posedge a_clk); #1;
      if (m_axil_wvalid === 1'b1 && !a_rst) begin
        repeat (w_dly) begin @(posedge a_clk); #1; end
        m_axil_wready = 1'b1;
        @(posedge a_clk); #1;
        m_axil_wready = 1'b0;
      end
    end
  end

  initial begin
    m_axil_bvalid = 1'b0;
    m_axil_bresp  = 2'b00;
    forever begin
      @(posedge a_clk); #1;
      if (!b_hold && aw_pend && w_pend) begin
        repeat (b_dly) begin @(posedge a_clk); #1; end
        for (int i = 0; i < 4; i++)
          if (w_strb_l[i]) mem[aw_addr_l[9:2]][8*i +: 8] = w_data_l[8*i +: 8];
        aw_pend = 1'b0;
        w_pend  = 1'b0;
        m_axil_bresp  = b_resp_cfg;
        m_axil_bvalid = 1'b1;
        for (int n = 0; n < 1000 && m_axil_bready !== 1'b1; n++) begin @(posedge a_clk); #1; end
        @(posedge a_clk); #1;
        m_axil_bvalid = 1'b0;
      end
    end
  end

  initial begin
    m_axil_arready = 1'b0;
    forever begin
      @(posedge a_clk); #1;
      if (m_axil_arvalid === 1'b1 && !a_rst) begin
        repeat (ar_dly) begin @(posedge a_clk); #1; end
        m_axil_arready = 1'b1;
        @(posedge a_clk); #1;
        m_axil_arready = 1'b0;
      end
    end
  end

  initial begin
    m_axil_rvalid = 1'b0;
    m_axil_rdata  = '0;
    m_axil_rresp  = 2'b00;
    forever begin
      @(posedge a_clk); #1;
      if (ar_pend) begin
        repeat (r_dly) begin @(posedge a_clk); #1; end
        ar_pend = 1'b0;
        m_axil_rdata  = mem[ar_addr_l[9:2]];
        m_axil_rresp  = r_resp_cfg;
        m_axil_rvalid = 1'b1;
        for (int n = 0; n < 1000 && m_axil_rready !== 1'b1; n++) begin @(posedge a_clk); #1; end
        @(posedge a_clk); #1;
        m_axil_rvalid = 1'b0;
      end
    end
  end

  // Handshake monitor and response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge a_clk);
      if (m_axil_awvalid === 1'b1 && m_axil_awready) begin
        aw_hs++; aw_pend = 1'b1; aw_addr_l = m_axil_awaddr;
      end
      if (m_axil_wvalid === 1'b1 && m_axil_wready) begin
        w_hs++; w_pend = 1'b1; w_data_l = m_axil_wdata; w_strb_l = m_axil_wstrb;
      end
      if (m_axil_bvalid && m_axil_bready === 1'b1) b_hs++;
      if (m_axil_arvalid === 1'b1 && m_axil_arready) begin
        ar_hs++; ar_pend = 1'b1; ar_addr_l = m_axil_araddr;
      end
      if (m_axil_rvalid && m_axil_rready === 1'b1) r_hs++;
      if (rsp_valid === 1'b1 && rsp_ready) begin
        check("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_resp",  64'(rsp_resp),  64'(e.resp));
          check("rsp_write", 64'(rsp_write), 64'(e.write));
        end
        rsp_cnt++;
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit expect_rsp);
    exp_t e;
    int   n;
    @(negedge a_clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
    check("cmd_accept_timeout", 64'(n < 200), 64'd1);
    if (expect_rsp) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) shadow[addr[9:2]][8*i +: 8] = data[8*i +: 8];
        e.rdata = '0; e.resp = b_resp_cfg; e.write = 1'b1;
      end else begin
        e.rdata = shadow[addr[9:2]]; e.resp = r_resp_cfg; e.write = 1'b0;
      end
      sb.push_back(e);
      exp_rsp++;
    end
    @(negedge a_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_cnt < exp_rsp && n < 500) begin @(negedge a_clk); n++; end
    check("rsp_timeout", 64'(rsp_cnt >= exp_rsp), 64'd1);
  endtask

  task automatic set_rsp_ready(input logic v);
    @(posedge a_clk); #1;
    rsp_ready = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    a_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge a_clk);
    check("reset_ctrl", 64'({cmd_ready, rsp_valid, m_axil_awvalid, m_axil_wvalid,
                             m_axil_bready, m_axil_arvalid, m_axil_rready}), 64'd0);
    check("prot", 64'({m_axil_awprot, m_axil_arprot}), 64'd0);
    a_rst = 1'b0;
    @(negedge a_clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // Write, AW and W accepted in the same cycle
    send_cmd(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b1);
    check("wr_aw_w_valid", 64'({m_axil_awvalid, m_axil_wvalid}), 64'd3);
    wait_rsp();
    check("wr1_hs", 64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}), 64'h010101);

    // Write, W accepted 3 cycles before AW
    aw_dly = 3;
    send_cmd(1'b1, 16'h0008, 32'h12345678, 4'b0011, 1'b1);
    @(negedge a_clk);
    check("wr2_w_dropped_aw_held", 64'({m_axil_awvalid, m_axil_wvalid}), 64'd2);
    wait_rsp();
    aw_dly = 0;
    check("wr2_hs", 64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}), 64'h020202);
    check("wr2_awaddr", 64'(aw_addr_l), 64'h0008);
    check("wr2_wdata_wstrb", 64'({w_data_l, w_strb_l}), 64'h123456783);

    // Write returning DECERR with a slow B channel
    b_resp_cfg = AXI_RESP_DECERR; b_dly = 2;
    send_cmd(1'b1, 16'h0020, 32'hA5A5A5A5, 4'hF, 1'b1);
    wait_rsp();
    b_resp_cfg = AXI_RESP_OKAY; b_dly = 0;

    // Read back with R delayed 5 cycles
    r_dly = 5;
    send_cmd(1'b0, 16'h0004, 32'h0, 4'h0, 1'b1);
    check("rd_arvalid", 64'(m_axil_arvalid), 64'd1);
    repeat (3) @(negedge a_clk);
    check("rd_rready_held", 64'({m_axil_rready, rsp_valid}), 64'd2);
    wait_rsp();
    r_dly = 0;
    check("rd_ar_r_hs", 64'({8'(ar_hs), 8'(r_hs)}), 64'h0101);

    // SLVERR read with the response port stalled for 4 cycles
    r_resp_cfg = AXI_RESP_SLVERR;
    set_rsp_ready(1'b0);
    send_cmd(1'b0, 16'h0004, 32'h0, 4'h0, 1'b1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
    check("stall_rsp_valid_timeout", 64'(n < 200), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      check("stall_rsp_resp", 64'(rsp_resp), 64'(AXI_RESP_SLVERR));
      check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge a_clk);
    end
    set_rsp_ready(1'b1);
    wait_rsp();
    r_resp_cfg = AXI_RESP_OKAY;
    @(negedge a_clk);
    check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);

    // Reset while waiting in WR_B
    b_hold = 1'b1;
    send_cmd(1'b1, 16'h0010, 32'h0BADF00D, 4'hF, 1'b0);
    n = 0;
    while (m_axil_bready !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
    check("wrb_reached", 64'(n < 200), 64'd1);
    a_rst = 1'b1;
    @(negedge a_clk);
    check("midreset_ctrl", 64'({cmd_ready, rsp_valid, m_axil_awvalid, m_axil_wvalid,
                                m_axil_bready, m_axil_arvalid, m_axil_rready}), 64'd0);
    a_rst = 1'b0; aw_pend = 1'b0; w_pend = 1'b0; b_hold = 1'b0;
    @(negedge a_clk);
    check("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge a_clk);
    check("midreset_no_rsp", 64'({8'(rsp_cnt), 7'd0, rsp_valid, 8'(b_hs)}), 64'({8'(exp_rsp), 8'd0, 8'd3}));

    // Back-to-back traffic: 16 writes then 16 reads
    for (int i = 0; i < 16; i++) begin
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); b_dly = $urandom_range(0, 2);
      send_cmd(1'b1, 16'h0100 + 16'(i * 4), $urandom, 4'hF, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      ar_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 3);
      send_cmd(1'b0, 16'h0100 + 16'(i * 4), 32'h0, 4'h0, 1'b1);
    end
    wait_rsp();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
